// File: rtl/if_pkg.sv
// +----------------------------------------------------------------------------+
// | if_pkg: counter states, BTB entry layout and default reset PC for fetch.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package if_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sized for the smallest BTB (4 entries); deeper tables zero-extend their tag.
  localparam int TAG_MAX_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_if.sv
// +----------------------------------------------------------------------------+
// | if_fetch_if: pipeline-side control, BTB update and fetch outputs.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface if_fetch_if;
  logic        LU_hazard;
  logic        Pcsrc;
  logic [31:0] Redirect_pc;
  logic        Jump;
  logic [31:0] Jump_pc;
  logic        Upd_valid;
  logic [31:0] Upd_pc;
  logic [31:0] Upd_target;
  logic        Upd_taken;
  logic [31:0] Imem_addr;
  logic [31:0] Pc_out;
  logic        Predict_Taken_IF;

  modport master (
    output LU_hazard, Pcsrc, Redirect_pc, Jump, Jump_pc,
    output Upd_valid, Upd_pc, Upd_target, Upd_taken,
    input  Imem_addr, Pc_out, Predict_Taken_IF
  );

  modport slave (
    input  LU_hazard, Pcsrc, Redirect_pc, Jump, Jump_pc,
    input  Upd_valid, Upd_pc, Upd_target, Upd_taken,
    output Imem_addr, Pc_out, Predict_Taken_IF
  );
endinterface

`default_nettype wire

// File: rtl/if_btb.sv
// +----------------------------------------------------------------------------+
// | if_btb: direct-mapped BTB, combinational lookup, registered update port.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_btb
  import if_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] lookup_pc,
  output logic             lookup_taken,
  output logic [31:0]      lookup_target,
  input  wire logic        upd_valid,
  input  wire logic [31:0] upd_pc,
  input  wire logic [31:0] upd_target,
  input  wire logic        upd_taken
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t r_btb [BTB_ENTRIES];

  logic [IDX-1:0]       w_lk_idx;
  logic [TAG_MAX_W-1:0] w_lk_tag;
  btb_entry_t           w_lk_ent;
  logic [IDX-1:0]       w_up_idx;
  logic [TAG_MAX_W-1:0] w_up_tag;
  btb_entry_t           w_up_ent;
  logic                 w_up_hit;
  logic [1:0]           w_up_ctr;
  logic                 w_unused;

  assign w_lk_idx = lookup_pc[IDX+1:2];
  assign w_lk_tag = TAG_MAX_W'(lookup_pc[31:IDX+2]);
  assign w_lk_ent = r_btb[w_lk_idx];

  // Lookup sees the array before any same-cycle update lands.
  assign lookup_taken  = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag) && w_lk_ent.ctr[1];
  assign lookup_target = w_lk_ent.target;

  assign w_up_idx = upd_pc[IDX+1:2];
  assign w_up_tag = TAG_MAX_W'(upd_pc[31:IDX+2]);
  assign w_up_ent = r_btb[w_up_idx];
  assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);
  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

  always_comb begin
    w_up_ctr = w_up_ent.ctr;
    if (upd_taken) begin
      if (w_up_ent.ctr != ST) w_up_ctr = w_up_ent.ctr + 2'd1;
    end else begin
      if (w_up_ent.ctr != SNT) w_up_ctr = w_up_ent.ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (upd_valid) begin
      if (w_up_hit) begin
        r_btb[w_up_idx].ctr <= w_up_ctr;
        if (upd_taken) r_btb[w_up_idx].target <= upd_target;
      end else if (upd_taken) begin
        r_btb[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: upd_target, ctr: WT};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// +----------------------------------------------------------------------------+
// | if_fetch: PC register and next-PC priority mux; BTB present with IF_BTB_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          BTB_ENTRIES = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  if_fetch_if.slave bus
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_btb_pred;
  logic [31:0] w_btb_target;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef IF_BTB_EN
  if_btb #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (r_pc),
    .lookup_taken  (w_btb_pred),
    .lookup_target (w_btb_target),
    .upd_valid     (bus.Upd_valid),
    .upd_pc        (bus.Upd_pc),
    .upd_target    (bus.Upd_target),
    .upd_taken     (bus.Upd_taken)
  );
`else
  logic        w_upd_unused;
  logic [31:0] w_btb_cfg_unused;

  assign w_btb_pred       = 1'b0;
  assign w_btb_target     = 32'h0;
  assign w_upd_unused     = ^{bus.Upd_valid, bus.Upd_pc, bus.Upd_target, bus.Upd_taken};
  assign w_btb_cfg_unused = BTB_ENTRIES;
`endif

  // Resolved redirects outrank the load-use stall so a flush is never lost.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (bus.Pcsrc)          w_next_pc = bus.Redirect_pc;
    else if (bus.Jump)      w_next_pc = bus.Jump_pc;
    else if (bus.LU_hazard) w_next_pc = r_pc;
    else if (w_btb_pred)    w_next_pc = w_btb_target;
    w_next_pc[1:0] = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_next_pc;
  end

  assign bus.Imem_addr        = r_pc;
  assign bus.Pc_out           = w_pc_plus4;
  assign bus.Predict_Taken_IF = w_btb_pred;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_if_fetch: directed plus random stimulus against a table-based model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_fetch;

  localparam int          N    = 16;
  localparam int          IDX  = 4;
  localparam logic [31:0] RPC  = 32'h0000_0000;
`ifdef IF_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_fetch_if bus();

  if_fetch #(
    .RESET_PC    (RPC),
    .BTB_ENTRIES (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: fetch address plus a table of (valid, tag, target, 0..3 confidence).
  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'(N));
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int i;
    i = m_idx(a);
    return m_valid[i] && (m_tag[i] == (a >> (IDX + 2)));
  endfunction

  function automatic bit m_pred(input logic [31:0] a);
    if (!BTB_ON) return 1'b0;
    return m_hit(a) && (m_ctr[m_idx(a)] >= 2);
  endfunction

  task automatic m_reset();
    m_pc = RPC;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'h0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outputs(input logic [31:0] pc, input bit pred);
    chk_val("imem_addr", bus.Imem_addr, pc);
    chk_val("pc_out", bus.Pc_out, pc + 32'd4);
    chk_val("predict", {31'b0, bus.Predict_Taken_IF}, {31'b0, pred});
  endtask

  // Entered and left at posedge+1; outputs checked at the following negedge.
  task automatic cycle(input bit lu, input bit pcsrc, input logic [31:0] rpc,
                       input bit jump, input logic [31:0] jpc,
                       input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input bit ut);
    bit          pred;
    logic [31:0] nxt;
    int          i;
    bus.LU_hazard = lu;   bus.Pcsrc = pcsrc; bus.Redirect_pc = rpc;
    bus.Jump = jump;      bus.Jump_pc = jpc;
    bus.Upd_valid = uv;   bus.Upd_pc = upc;  bus.Upd_target = utgt; bus.Upd_taken = ut;
    @(negedge clk);
    pred = m_pred(m_pc);
    chk_outputs(m_pc, pred);
    if (pcsrc)     nxt = rpc;
    else if (jump) nxt = jpc;
    else if (lu)   nxt = m_pc;
    else if (pred) nxt = m_tgt[m_idx(m_pc)];
    else           nxt = m_pc + 32'd4;
    nxt = nxt & 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    if (BTB_ON && uv) begin
      i = m_idx(upc);
      if (m_hit(upc)) begin
        m_ctr[i] = ut ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (ut) m_tgt[i] = utgt;
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = upc >> (IDX + 2);
        m_tgt[i]   = utgt;
        m_ctr[i]   = 2;
      end
    end
    m_pc = nxt;
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic jump_to(input logic [31:0] a);
    cycle(0, 0, 32'h0, 1, a, 0, 32'h0, 32'h0, 0);
  endtask

  // Updates issued under a load-use stall: the PC holds while the BTB trains.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    cycle(1, 0, 32'h0, 0, 32'h0, 1, pc, tgt, taken);
  endtask

  // Asserts reset mid-cycle with a live update that must be discarded.
  task automatic do_reset();
    bus.LU_hazard = 0; bus.Pcsrc = 0; bus.Jump = 0;
    bus.Redirect_pc = 32'h0; bus.Jump_pc = 32'h0;
    bus.Upd_valid = 1; bus.Upd_pc = 32'h20; bus.Upd_target = 32'h80; bus.Upd_taken = 1;
    #1;
    rst = 1'b1;
    #1;
    m_reset();
    chk_outputs(RPC, 1'b0);
    @(posedge clk);
    #1;
    chk_outputs(RPC, 1'b0);
    rst = 1'b0;
    bus.Upd_valid = 0;
  endtask

  initial begin
    m_reset();
    do_reset();
    repeat (3) idle();

    cycle(0, 1, 32'h10, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    cycle(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    cycle(1, 1, 32'h40, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    idle();

    upd(32'h20, 32'h80, 1);
    jump_to(32'h20);
    idle();
    idle();

    upd(32'h20, 32'h80, 0);
    jump_to(32'h20);
    idle();
    idle();
    upd(32'h20, 32'h80, 1);
    upd(32'h20, 32'h80, 1);
    upd(32'h20, 32'h80, 0);
    jump_to(32'h20);
    idle();
    idle();

    jump_to(32'h420);
    idle();
    jump_to(32'hFFFF_FFFC);
    idle();
    idle();

    cycle(0, 1, 32'h100, 1, 32'h200, 0, 32'h0, 32'h0, 0);
    idle();
    jump_to(32'h203);
    idle();

    for (int k = 0; k < 400; k++) begin
      logic [31:0] rpc, jpc, upc;
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      jpc = 32'($urandom_range(0, 255)) << 2;
      upc = (32'($urandom_range(0, 63)) << 2) | (($urandom_range(0, 3) == 0) ? 32'h400 : 32'h0);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rpc,
            $urandom_range(0, 7) == 0, jpc,
            $urandom_range(0, 1) == 1, upc, 32'($urandom_range(0, 255)) << 2,
            $urandom_range(0, 2) != 0);
    end

    do_reset();
    jump_to(32'h20);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16: BTB depth, power of two, 4 to 64.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port LU_hazard  input  1  load-use stall; holds PC.
REQ-006 SHALL have port Pcsrc  input  1  resolved-branch redirect; same signal that flushes IF_ID.
REQ-007 SHALL have port Redirect_pc  input  32  corrected fetch address, valid with Pcsrc.
REQ-008 SHALL have port Jump  input  1  jump/jal/jr redirect; same signal that flushes IF_ID.
REQ-009 SHALL have port Jump_pc  input  32  jump destination, valid with Jump.
REQ-010 SHALL have port Upd_valid  input  1  BTB update strobe from branch resolution.
REQ-011 SHALL have port Upd_pc  input  32  address of the resolved branch.
REQ-012 SHALL have port Upd_target  input  32  resolved taken-target.
REQ-013 SHALL have port Upd_taken  input  1  resolved outcome.
REQ-014 SHALL have port Imem_addr  output  32  current PC to instruction memory.
REQ-015 SHALL have port Pc_out  output  32  Imem_addr+4, feeds IF_ID Pc_out.
REQ-016 SHALL have port Predict_Taken_IF  output  1  BTB taken prediction for Imem_addr, feeds IF_ID.

Function
REQ-017 SHALL compute next PC by priority: Pcsrc->Redirect_pc; else Jump->Jump_pc; else LU_hazard->hold; else Predict_Taken_IF->BTB target; else PC+4.
REQ-018 SHALL let Pcsrc and Jump override LU_hazard in the same cycle.
REQ-019 SHALL force bits [1:0] of every loaded PC to 2'b00.
REQ-020 SHALL wrap PC+4 modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 SHALL produce Imem_addr, Pc_out and Predict_Taken_IF combinationally from the PC register and BTB, with zero-cycle latency.
REQ-022 SHALL index the BTB with PC[IDX+1:2], IDX=log2(BTB_ENTRIES), tag PC[31:IDX+2]; each entry holds valid, tag, 32-bit target and a 2-bit counter.
REQ-023 SHALL assert Predict_Taken_IF iff entry valid, tag matches and counter[1]==1.
REQ-024 SHALL use counter states SNT=00, WNT=01, WT=10, ST=11: taken increments and not-taken decrements, saturating at ST and SNT.
REQ-025 SHALL, on Upd_valid with a hit, update the counter and, if Upd_taken, also write the target.
REQ-026 SHALL, on Upd_valid with a miss and Upd_taken=1, allocate the entry: valid=1, tag, target, counter=WT.
REQ-027 SHALL leave the BTB unchanged on a miss with Upd_taken=0.
REQ-028 SHALL return pre-update contents when a lookup and an update hit the same index in one cycle, with no bypass.
REQ-029 SHALL let BTB updates proceed during LU_hazard, Pcsrc and Jump.

Reset
REQ-030 SHALL, while rst=1, hold PC=RESET_PC, clear all BTB valid bits and set all counters to WNT, independent of clk.
REQ-031 SHALL drive Imem_addr=RESET_PC, Pc_out=RESET_PC+4 and Predict_Taken_IF=0 during reset.
REQ-032 SHALL resume fetch at RESET_PC on the first rising edge after rst deasserts, discarding any update arriving in that cycle's reset window.

Configuration
REQ-033 SHALL, with IF_BTB_EN defined, implement the BTB per REQ-022 to REQ-029.
REQ-034 SHALL, without IF_BTB_EN, instantiate no BTB storage, tie Predict_Taken_IF=0, ignore the Upd_* inputs and keep all other behaviour identical (static predict-not-taken).

Structure
REQ-035 SHALL take from shared package if_pkg: counter-state constants (SNT/WNT/WT/ST), the BTB entry struct typedef and the default RESET_PC.
REQ-036 SHALL place the BTB in sub-module if_btb (lookup port plus update port); if_fetch holds the PC register and next-PC mux.

Verification
REQ-037 SHALL cover reset then free run: rst pulse -> Imem_addr 0x0, 0x4, 0x8 on successive edges, Predict_Taken_IF=0.
REQ-038 SHALL cover stall vs redirect: LU_hazard=1 at PC 0x10 -> PC holds 0x10; LU_hazard=1 and Pcsrc=1 with Redirect_pc=0x40 -> next PC 0x40.
REQ-039 SHALL cover BTB allocate and predict: Upd_valid, Upd_pc=0x20, Upd_target=0x80, Upd_taken=1 -> next fetch of 0x20 gives Predict_Taken_IF=1 and next PC 0x80.
REQ-040 SHALL cover counter hysteresis: from WT at 0x20, one not-taken update -> WNT, predict 0 and next PC 0x24; two taken updates -> ST; one not-taken -> WT, still predicts 1.
REQ-041 SHALL cover alias and wrap: with 16 entries, entry at 0x20 and lookup at 0x420 (same index, tag differs) -> predict 0; PC 0xFFFF_FFFC -> next PC 0x0.
REQ-042 SHALL cover priority: Pcsrc=1 (0x100) and Jump=1 (0x200) in the same cycle -> next PC 0x100.
